flag_unit: RTL and testbench
============================

Name: flag_unit

Overview:
- Produces and holds the architectural N/Z/C/V flags that the branch-condition evaluator consumes.
- Computes flags from ALU writeback when the instruction sets flags.
- Supports direct flag writes from the flag-restore instruction.
- Keeps a small LIFO save stack: flags are pushed on call and restored on return, so conditional returns see the caller's flags.

Parameters:
- WIDTH, 8, datapath width of ALU operands/result.
- DEPTH, 4, number of entries in the flag save stack (power of two, >=2).

Ports:
- clk  in  1  clock, all state rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- set_flags  in  1  ALU result valid this cycle and instruction updates flags.
- is_sub  in  1  ALU op was subtract/compare (selects V formula).
- op_a  in  WIDTH  ALU operand A.
- op_b  in  WIDTH  ALU operand B (un-inverted, as encoded).
- result  in  WIDTH  ALU result.
- carry_out  in  1  ALU carry (for sub: 1 = no borrow).
- flags_wr  in  1  direct flag write.
- flags_wdata  in  4  {N,Z,C,V} for direct write.
- push  in  1  save current flags (call).
- pop  in  1  restore flags from stack (return).
- err_clr  in  1  clear sticky stack_err.
- flagn, flagz, flagc, flagv  out  1 each  registered architectural flags.
- stack_count  out  $clog2(DEPTH)+1  valid entries.
- stack_full  out  1  stack_count == DEPTH.
- stack_empty  out  1  stack_count == 0.
- stack_err  out  1  sticky overflow/underflow indicator.

Behaviour:
- Reset (async assert, sync-safe deassert): all flags 0, stack_count 0, stack_empty 1, stack_full 0, stack_err 0. Stack storage contents are don't-care.
- Flag computation (combinational, registered on set_flags):
  - N = result[WIDTH-1].
  - Z = (result == 0).
  - C = carry_out.
  - V for add: (a_msb == b_msb) & (r_msb != a_msb).
  - V for sub: (a_msb != b_msb) & (r_msb != a_msb).
- Latency: flag outputs change one cycle after the qualifying input edge. There is no combinational path from inputs to flag outputs.
- Live-flag update priority per cycle: pop (valid, non-empty) > flags_wr > set_flags > hold.
- Push:
  - If not full, write the current registered flags (the value before any same-cycle update) at index stack_count; count increments.
  - A same-cycle set_flags/flags_wr still updates the live flags.
- Pop:
  - If not empty, live flags load the entry at stack_count-1; count decrements.
- push & pop in the same cycle: stack and count unchanged, pop does not restore. Live flags follow flags_wr/set_flags priority. No error, even when empty or full.
- Push while full: entry dropped, count holds at DEPTH, stack_err <= 1.
- Pop while empty: live flags follow the lower-priority sources, count stays 0, stack_err <= 1.
- stack_err is sticky until err_clr. If err_clr and a new error occur in the same cycle, the error wins (err stays 1).
- stack_full/stack_empty are decoded from the registered count, so no extra latency.

Test Plan:
- Add overflow: set_flags=1, is_sub=0, a=0x7F, b=0x01, result=0x80, carry=0 -> next cycle N=1 Z=0 C=0 V=1.
- Compare equal: is_sub=1, a=0x05, b=0x05, result=0x00, carry=1 -> N=0 Z=1 C=1 V=0. Then is_sub=1, a=0x80, b=0x01, result=0x7F, carry=1 -> V=1, N=0.
- Save/restore: flags_wr 4'b1010 -> push -> set_flags to produce 0000 -> pop -> flags 1010, count 1->0, stack_err 0.
- Overflow (DEPTH=4): 5 pushes with distinct flags_wr values 0001..0101 -> count 4, full 1, stack_err 1. Then 4 pops return 0100, 0011, 0010, 0001 in order.
- Underflow and priority: pop when empty with set_flags producing Z=1 -> Z=1, count 0, stack_err 1. err_clr -> 0. push+pop together with count 2 -> count stays 2, flags unchanged.
- Reset mid-operation: count 3, flags 1111, assert rst_n low between edges -> outputs 0 and empty=1 immediately. After release, pop -> stack_err 1.

Source files
------------

// File: rtl/flag_unit_if.sv
// Bundles the ALU writeback, flag-write, save-stack controls and flag outputs
// of flag_unit into one port. The master drives the controls; the slave is the flag unit.
interface flag_unit_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic             set_flags;
   logic             is_sub;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] result;
   logic             carry_out;
   logic             flags_wr;
   logic [3:0]       flags_wdata;
   logic             push;
   logic             pop;
   logic             err_clr;
   logic             flagn;
   logic             flagz;
   logic             flagc;
   logic             flagv;
   logic [CW-1:0]    stack_count;
   logic             stack_full;
   logic             stack_empty;
   logic             stack_err;

   modport master (
      output set_flags, is_sub, op_a, op_b, result, carry_out,
             flags_wr, flags_wdata, push, pop, err_clr,
      input  flagn, flagz, flagc, flagv,
             stack_count, stack_full, stack_empty, stack_err
   );

   modport slave (
      input  set_flags, is_sub, op_a, op_b, result, carry_out,
             flags_wr, flags_wdata, push, pop, err_clr,
      output flagn, flagz, flagc, flagv,
             stack_count, stack_full, stack_empty, stack_err
   );
endinterface

// File: rtl/flag_unit.sv
// Architectural N/Z/C/V flag register with a LIFO save stack used across
// call/return, plus a sticky overflow/underflow indicator.
module flag_unit #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   flag_unit_if.slave  bus
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int PW = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   // Flag word layout is {N,Z,C,V}.
   function automatic logic [3:0] calc_flags(input logic [WIDTH-1:0] r,
                                             input logic a_msb,
                                             input logic b_msb,
                                             input logic c,
                                             input logic sub);
      logic v;
      if (sub) v = (a_msb != b_msb) && (r[WIDTH-1] != a_msb);
      else     v = (a_msb == b_msb) && (r[WIDTH-1] != a_msb);
      return {r[WIDTH-1], (r == '0), c, v};
   endfunction

   logic [3:0]    flags_q, flags_d;
   logic [CW-1:0] count_q, count_d;
   logic          err_q, err_d;
   logic [3:0]    stack_q [DEPTH];
   logic [3:0]    stack_d [DEPTH];

   logic          full, empty;
   logic          push_only, pop_only, do_push, do_pop, err_new;
   logic [PW-1:0] push_idx, pop_idx;

   assign full      = (count_q == FULL_CNT);
   assign empty     = (count_q == '0);
   assign push_only = bus.push & ~bus.pop;
   assign pop_only  = bus.pop & ~bus.push;
   assign do_push   = push_only & ~full;
   assign do_pop    = pop_only & ~empty;
   assign err_new   = (push_only & full) | (pop_only & empty);
   assign push_idx  = count_q[PW-1:0];
   assign pop_idx   = count_q[PW-1:0] - PW'(1);

   always_comb begin
      flags_d = flags_q;
      count_d = count_q;
      err_d   = err_q;
      stack_d = stack_q;

      if (do_pop)            flags_d = stack_q[pop_idx];
      else if (bus.flags_wr) flags_d = bus.flags_wdata;
      else if (bus.set_flags)
         flags_d = calc_flags(bus.result, bus.op_a[WIDTH-1], bus.op_b[WIDTH-1],
                              bus.carry_out, bus.is_sub);

      // The saved value is the pre-update flags, so a same-cycle write does not leak in.
      if (do_push) begin
         stack_d[push_idx] = flags_q;
         count_d           = count_q + CW'(1);
      end else if (do_pop) begin
         count_d = count_q - CW'(1);
      end

      if (err_new)          err_d = 1'b1;
      else if (bus.err_clr) err_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q <= 4'b0000;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         flags_q <= flags_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   // Stack storage needs no reset; entries are only read below the valid count.
   always_ff @(posedge clk) begin
      stack_q <= stack_d;
   end

   assign bus.flagn       = flags_q[3];
   assign bus.flagz       = flags_q[2];
   assign bus.flagc       = flags_q[1];
   assign bus.flagv       = flags_q[0];
   assign bus.stack_count = count_q;
   assign bus.stack_full  = full;
   assign bus.stack_empty = empty;
   assign bus.stack_err   = err_q;
endmodule

// File: tb/tb_flag_unit.sv
// Directed bench for flag_unit: ALU flag formulas, direct writes, save stack,
// error stickiness and asynchronous reset.
module tb_flag_unit;
   logic clk;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;

   flag_unit_if #(.WIDTH(8), .DEPTH(4)) bus ();

   flag_unit #(.WIDTH(8), .DEPTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] nzcv();
      return {bus.flagn, bus.flagz, bus.flagc, bus.flagv};
   endfunction

   task automatic idle();
      bus.set_flags   = 1'b0;
      bus.is_sub      = 1'b0;
      bus.op_a        = 8'h00;
      bus.op_b        = 8'h00;
      bus.result      = 8'h00;
      bus.carry_out   = 1'b0;
      bus.flags_wr    = 1'b0;
      bus.flags_wdata = 4'b0000;
      bus.push        = 1'b0;
      bus.pop         = 1'b0;
      bus.err_clr     = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic alu(input logic sub, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] r, input logic c);
      bus.set_flags = 1'b1;
      bus.is_sub    = sub;
      bus.op_a      = a;
      bus.op_b      = b;
      bus.result    = r;
      bus.carry_out = c;
   endtask

   task automatic wr(input logic [3:0] f);
      bus.flags_wr    = 1'b1;
      bus.flags_wdata = f;
   endtask

   logic [3:0] pop_exp [4];

   initial begin
      idle();
      rst_n = 1'b0;
      #1;
      check("rst_flags", nzcv(), 4'b0000);
      check("rst_count", bus.stack_count, 0);
      check("rst_empty", bus.stack_empty, 1);
      check("rst_full", bus.stack_full, 0);
      check("rst_err", bus.stack_err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Add overflow; flags must not move before the edge.
      alu(1'b0, 8'h7F, 8'h01, 8'h80, 1'b0);
      #2;
      check("no_comb_path", nzcv(), 4'b0000);
      tick();
      check("add_ovf", nzcv(), 4'b1001);

      alu(1'b1, 8'h05, 8'h05, 8'h00, 1'b1);
      tick();
      check("cmp_eq", nzcv(), 4'b0110);
      alu(1'b1, 8'h80, 8'h01, 8'h7F, 1'b1);
      tick();
      check("sub_ovf", nzcv(), 4'b0011);

      // Save/restore
      wr(4'b1010);
      tick();
      check("wr_1010", nzcv(), 4'b1010);
      bus.push = 1'b1;
      tick();
      check("push_cnt1", bus.stack_count, 1);
      alu(1'b0, 8'h00, 8'h01, 8'h01, 1'b0);
      tick();
      check("add_0000", nzcv(), 4'b0000);
      bus.pop = 1'b1;
      tick();
      check("pop_restore", nzcv(), 4'b1010);
      check("pop_cnt0", bus.stack_count, 0);
      check("pop_err0", bus.stack_err, 0);

      // Overflow: five pushes of 0001..0101, the last one is dropped
      for (int k = 1; k <= 5; k++) begin
         wr(4'(k));
         tick();
         bus.push = 1'b1;
         tick();
      end
      check("ovf_cnt", bus.stack_count, 4);
      check("ovf_full", bus.stack_full, 1);
      check("ovf_err", bus.stack_err, 1);
      pop_exp = '{4'b0100, 4'b0011, 4'b0010, 4'b0001};
      for (int k = 0; k < 4; k++) begin
         bus.pop = 1'b1;
         tick();
         check($sformatf("lifo_pop%0d", k), nzcv(), pop_exp[k]);
      end
      check("lifo_empty", bus.stack_empty, 1);

      // Underflow with lower-priority set_flags
      bus.err_clr = 1'b1;
      tick();
      check("err_clr", bus.stack_err, 0);
      bus.pop = 1'b1;
      alu(1'b1, 8'h05, 8'h05, 8'h00, 1'b1);
      tick();
      check("unf_flags", nzcv(), 4'b0110);
      check("unf_cnt", bus.stack_count, 0);
      check("unf_err", bus.stack_err, 1);
      bus.err_clr = 1'b1;
      tick();
      check("unf_clr", bus.stack_err, 0);
      bus.err_clr = 1'b1;
      bus.pop     = 1'b1;
      tick();
      check("err_beats_clr", bus.stack_err, 1);
      bus.err_clr = 1'b1;
      tick();
      check("err_clr2", bus.stack_err, 0);

      // push+pop together at count 2
      bus.push = 1'b1;
      tick();
      wr(4'b1100);
      tick();
      bus.push = 1'b1;
      tick();
      check("pp_pre_cnt", bus.stack_count, 2);
      bus.push = 1'b1;
      bus.pop  = 1'b1;
      tick();
      check("pp_cnt", bus.stack_count, 2);
      check("pp_flags", nzcv(), 4'b1100);
      check("pp_err", bus.stack_err, 0);
      bus.push = 1'b1;
      bus.pop  = 1'b1;
      wr(4'b0101);
      tick();
      check("pp_wr_flags", nzcv(), 4'b0101);
      check("pp_wr_cnt", bus.stack_count, 2);
      bus.pop = 1'b1;
      tick();
      check("pp_pop1", nzcv(), 4'b1100);
      bus.pop = 1'b1;
      tick();
      check("pp_pop2", nzcv(), 4'b0110);
      check("pp_empty", bus.stack_empty, 1);

      // Async reset mid-operation
      wr(4'b1111);
      tick();
      for (int k = 0; k < 3; k++) begin
         bus.push = 1'b1;
         tick();
      end
      check("pre_rst_cnt", bus.stack_count, 3);
      check("pre_rst_flags", nzcv(), 4'b1111);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_flags", nzcv(), 4'b0000);
      check("arst_cnt", bus.stack_count, 0);
      check("arst_empty", bus.stack_empty, 1);
      @(negedge clk);
      rst_n = 1'b1;
      bus.pop = 1'b1;
      tick();
      check("post_rst_err", bus.stack_err, 1);
      check("post_rst_cnt", bus.stack_count, 0);
      check("post_rst_flags", nzcv(), 4'b0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
